// File: rtl/admo_alu_mc.sv
// Registered ALU with valid/ready handshake; single-cycle integer ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) taking DATA_WIDTH steps.
module admo_alu_mc #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MUL_ENABLE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [4:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W       = DATA_WIDTH;
  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  localparam logic [4:0] OpAdd   = 5'b00000;
  localparam logic [4:0] OpSub   = 5'b01000;
  localparam logic [4:0] OpSll   = 5'b00001;
  localparam logic [4:0] OpLts   = 5'b00010;
  localparam logic [4:0] OpLtu   = 5'b00011;
  localparam logic [4:0] OpXor   = 5'b00100;
  localparam logic [4:0] OpSrl   = 5'b00101;
  localparam logic [4:0] OpSra   = 5'b01101;
  localparam logic [4:0] OpOr    = 5'b00110;
  localparam logic [4:0] OpAnd   = 5'b00111;
  localparam logic [4:0] OpMul   = 5'b10000;
  localparam logic [4:0] OpMulhu = 5'b10011;
  localparam logic [4:0] OpDivu  = 5'b10101;
  localparam logic [4:0] OpRemu  = 5'b10111;

  localparam logic [SHAMT_W-1:0] CntLast = SHAMT_W'(W - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q;
  logic [4:0]         op_q;
  logic [W-1:0]       opb_q;
  logic [2*W-1:0]     acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [W-1:0]       result_q;
  logic               ready_q;
  logic               valid_q;

  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       alu_res;
  logic               is_m_op;
  logic               accept;

  assign shamt   = operand_b_i[SHAMT_W-1:0];
  assign is_m_op = operator_i inside {OpMul, OpMulhu, OpDivu, OpRemu};
  assign accept  = valid_i && ready_q && !flush_i;

  always_comb begin
    alu_res = operand_a_i;
    case (operator_i)
      OpAdd: alu_res = operand_a_i + operand_b_i;
      OpSub: alu_res = operand_a_i - operand_b_i;
      OpSll: alu_res = operand_a_i << shamt;
      OpLts: alu_res = {{(W-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      OpLtu: alu_res = {{(W-1){1'b0}}, operand_a_i < operand_b_i};
      OpXor: alu_res = operand_a_i ^ operand_b_i;
      OpSrl: alu_res = operand_a_i >> shamt;
      OpSra: alu_res = $unsigned($signed(operand_a_i) >>> shamt);
      OpOr:  alu_res = operand_a_i | operand_b_i;
      OpAnd: alu_res = operand_a_i & operand_b_i;
      // Reached only with MUL_ENABLE=0; M ops then collapse to a zero result.
      OpMul, OpMulhu, OpDivu, OpRemu: alu_res = '0;
      default: alu_res = operand_a_i;
    endcase
  end

  // Iteration datapath: acc_q = {partial/remainder, multiplier/quotient}.
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic [W:0]     div_trial;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] step_next;
  logic [W-1:0]   m_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_trial = div_shift - {1'b0, opb_q};
    if (!div_trial[W]) begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    end
    step_next = op_q[2] ? div_next : mul_next;
    case (op_q)
      OpMul:   m_res = mul_next[W-1:0];
      OpMulhu: m_res = mul_next[2*W-1:W];
      OpDivu:  m_res = div_next[W-1:0];
      default: m_res = div_next[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= StIdle;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (MUL_ENABLE && is_m_op) begin
              op_q  <= operator_i;
              cnt_q <= '0;
              if (operator_i[2]) begin
                acc_q <= {{W{1'b0}}, operand_a_i};
                opb_q <= operand_b_i;
              end else begin
                acc_q <= {{W{1'b0}}, operand_b_i};
                opb_q <= operand_a_i;
              end
              state_q <= StBusy;
            end else begin
              result_q <= alu_res;
              valid_q  <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StBusy: begin
          acc_q <= step_next;
          cnt_q <= cnt_q + 1'b1;
          // Last step's outcome goes straight into result_q, no extra cycle.
          if (cnt_q == CntLast) begin
            result_q <= m_res;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_admo_alu_mc.sv
// Directed bench for admo_alu_mc: 32-bit and 16-bit instances sharing clock, reset,
// flush, operator and operands; each instance has its own request strobe.
module tb_admo_alu_mc;

  localparam logic [4:0] OpAdd   = 5'b00000;
  localparam logic [4:0] OpSub   = 5'b01000;
  localparam logic [4:0] OpSll   = 5'b00001;
  localparam logic [4:0] OpLts   = 5'b00010;
  localparam logic [4:0] OpLtu   = 5'b00011;
  localparam logic [4:0] OpXor   = 5'b00100;
  localparam logic [4:0] OpSrl   = 5'b00101;
  localparam logic [4:0] OpSra   = 5'b01101;
  localparam logic [4:0] OpOr    = 5'b00110;
  localparam logic [4:0] OpAnd   = 5'b00111;
  localparam logic [4:0] OpMul   = 5'b10000;
  localparam logic [4:0] OpMulhu = 5'b10011;
  localparam logic [4:0] OpDivu  = 5'b10101;
  localparam logic [4:0] OpRemu  = 5'b10111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        rdy_in = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        v32 = 1'b0;
  logic        v16 = 1'b0;
  logic        ready32, valid32, ready16, valid16;
  logic [31:0] res32;
  logic [15:0] res16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  admo_alu_mc #(.DATA_WIDTH(32), .MUL_ENABLE(1'b1)) dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .operator_i(op),
    .operand_a_i(opa), .operand_b_i(opb), .flush_i(flush),
    .ready_o(ready32), .valid_o(valid32), .ready_i(rdy_in), .result_o(res32)
  );

  admo_alu_mc #(.DATA_WIDTH(16), .MUL_ENABLE(1'b1)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .operator_i(op),
    .operand_a_i(opa[15:0]), .operand_b_i(opb[15:0]), .flush_i(flush),
    .ready_o(ready16), .valid_o(valid16), .ready_i(rdy_in), .result_o(res16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_valid(input bit sel);
    return sel ? valid16 : valid32;
  endfunction

  function automatic logic f_ready(input bit sel);
    return sel ? ready16 : ready32;
  endfunction

  function automatic logic [31:0] f_res(input bit sel);
    return sel ? {16'h0, res16} : res32;
  endfunction

  // One full transaction: accept, latency in edges (accept edge counts as 1), result,
  // ready low while valid, then release with ready_i and expect IDLE.
  task automatic run(input bit sel, input string tag, input logic [4:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat);
    int lat;
    op = o; opa = a; opb = b;
    chk({tag, "_ready_before"}, 32'(f_ready(sel)), 32'd1);
    if (sel) v16 = 1'b1; else v32 = 1'b1;
    tick();
    v16 = 1'b0; v32 = 1'b0;
    // Scramble inputs to prove operands were latched at accept.
    op = OpSub; opa = 32'hDEADBEEF; opb = 32'h1234ABCD;
    lat = 1;
    while (!f_valid(sel) && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, f_res(sel), exp);
    chk({tag, "_ready_busy"}, 32'(f_ready(sel)), 32'd0);
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, f_ready(sel), f_valid(sel)}, 32'd2);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready32), 32'd1);
    chk("reset_valid", 32'(valid32), 32'd0);
    chk("reset_result", res32, 32'd0);
    rst = 1'b0;
    tick();

    run(0, "add_wrap", OpAdd, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run(0, "sub", OpSub, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run(0, "sra", OpSra, 32'h80000000, 32'h24, 32'hF8000000, 1);
    run(0, "srl", OpSrl, 32'h80000000, 32'h24, 32'h08000000, 1);
    run(0, "sll", OpSll, 32'h1, 32'h21, 32'h2, 1);
    run(0, "lts", OpLts, 32'hFFFFFFFF, 32'h1, 32'h1, 1);
    run(0, "ltu", OpLtu, 32'hFFFFFFFF, 32'h1, 32'h0, 1);
    run(0, "xor", OpXor, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run(0, "or", OpOr, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1);
    run(0, "and", OpAnd, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    run(0, "illegal_op", 5'b11111, 32'h12345678, 32'h9, 32'h12345678, 1);

    run(0, "mul", OpMul, 32'h00010003, 32'h00020005, 32'h000B000F, 33);
    run(0, "mulhu", OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run(0, "divu", OpDivu, 32'd100, 32'd7, 32'd14, 33);
    run(0, "remu", OpRemu, 32'd100, 32'd7, 32'd2, 33);
    run(0, "divu_by0", OpDivu, 32'd5, 32'd0, 32'hFFFFFFFF, 33);
    run(0, "remu_by0", OpRemu, 32'd5, 32'd0, 32'd5, 33);

    // Consumer backpressure: result and valid held while ready_i stays low.
    op = OpAdd; opa = 32'h11; opb = 32'h22; v32 = 1'b1;
    tick();
    v32 = 1'b0; opa = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(valid32), 32'd1);
      chk("hold_result", res32, 32'h33);
    end
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    chk("hold_release_ready", 32'(ready32), 32'd1);

    // Flush in the 10th cycle of a divide: back to IDLE, no result, old result kept.
    op = OpDivu; opa = 32'd1000; opb = 32'd3; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(valid32), 32'd0);
    chk("flush_ready", 32'(ready32), 32'd1);
    chk("flush_result_kept", res32, 32'h33);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid32) seen++;
    end
    chk("flush_no_late_valid", 32'(seen), 32'd0);
    run(0, "add_after_flush", OpAdd, 32'd2, 32'd3, 32'd5, 1);

    // valid_i together with flush_i must not be accepted.
    op = OpAdd; opa = 32'd9; opb = 32'd9; v32 = 1'b1; flush = 1'b1;
    tick();
    v32 = 1'b0; flush = 1'b0;
    chk("flush_blocks_accept", {30'd0, ready32, valid32}, 32'd2);

    // Asynchronous reset in the middle of a multiply.
    op = OpMul; opa = 32'd7; opb = 32'd9; v32 = 1'b1;
    tick();
    v32 = 1'b0;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid32), 32'd0);
    chk("async_rst_ready", 32'(ready32), 32'd1);
    chk("async_rst_result", res32, 32'd0);
    #2 rst = 1'b0;
    tick();

    run(1, "w16_mul", OpMul, 32'h0100, 32'h0100, 32'h0000, 17);
    run(1, "w16_mulhu", OpMulhu, 32'h0100, 32'h0100, 32'h0001, 17);
    run(1, "w16_divu", OpDivu, 32'hFFFF, 32'h0010, 32'h0FFF, 17);
    run(1, "w16_sra", OpSra, 32'h8000, 32'h0013, 32'hF000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
